fifo_word_packer: RTL and testbench

- Read-side consumer for the team's 8-bit synchronous FIFO (push/pop/din/dout/empty/full interface).
- Pops bytes whenever the FIFO is non-empty and packs them little-endian into BYTES-wide words.
- Presents each word on a valid/ready output stream; a flush request emits a partially filled word.
- Sits between the byte FIFO and word-oriented downstream logic (bus writer, DMA).

---
 rtl/fifo_word_packer.sv | 127 ++++++++++++
 tb/tb_fifo_word_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Drains an 8-bit synchronous FIFO (registered read) and packs the bytes
// little-endian into BYTES-wide words on a valid/ready output stream.
// A flush pulse emits whatever partial word has been assembled; upper
// lanes of a partial word are zero and m_count reports the filled lanes.
module fifo_word_packer #(
    parameter int DW    = 8,
    parameter int BYTES = 4,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fifo_empty,
    output logic                fifo_pop,
    input  logic [DW-1:0]       fifo_dout,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DW*BYTES-1:0] m_data,
    output logic [CW-1:0]       m_count
);

    localparam int WW = DW * BYTES;
    localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
    localparam logic [CW:0]   BYTES_W = (CW + 1)'(BYTES);

    // Assembly state: bytes captured so far and whether a pop is in flight.
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          flushp_q, flushp_d;
    logic [WW-1:0] asm_q, asm_d;

    // Output stage.
    logic          m_valid_q, m_valid_d;
    logic [WW-1:0] m_data_q, m_data_d;
    logic [CW-1:0] m_count_q, m_count_d;

    // Lane occupancy including the byte that is still in flight; one extra
    // bit so that cnt == BYTES-1 plus a pending byte never wraps.
    logic [CW:0]   occ;
    logic [CW-1:0] cnt_inc;

    assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
    assign cnt_inc = cnt_q + CW'(1);

    // Pop whenever a free lane exists, no word is waiting downstream and no
    // flush is draining; gated by rstn so nothing pops during reset.
    assign fifo_pop = rstn && !fifo_empty && !m_valid_q &&
                      (occ < BYTES_W) && !flushp_q;

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_count = m_count_q;

    // Next-state: handshake, byte capture, word completion and flush emission.
    always_comb begin
        cnt_d     = cnt_q;
        pend_d    = fifo_pop;
        flushp_d  = flushp_q | flush;
        asm_d     = asm_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;

        // Accepted word leaves; output registers return to zero.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_count_d = '0;
        end

        // Read data arrives the cycle after the pop; drop it into lane cnt.
        if (pend_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (cnt_q == CW'(i)) begin
                    asm_d[i*DW +: DW] = fifo_dout;
                end
            end
            cnt_d = cnt_inc;
        end

        if (pend_q && (cnt_inc == BYTES_C)) begin
            // Last lane filled: hand the word to the output stage and start
            // the next word from an all-zero assembly register. A flush that
            // lands now stays pending and later finds cnt == 0, so no empty
            // word follows.
            m_valid_d = 1'b1;
            m_data_d  = asm_d;
            m_count_d = BYTES_C;
            cnt_d     = '0;
            asm_d     = '0;
        end else if (flushp_q && !pend_q && !m_valid_q) begin
            // Flush only once the in-flight byte has landed and the output
            // stage is free; an empty assembly simply retires the request.
            if (cnt_q != '0) begin
                m_valid_d = 1'b1;
                m_data_d  = asm_q;
                m_count_d = cnt_q;
                cnt_d     = '0;
                asm_d     = '0;
            end
            flushp_d = flush;
        end
    end

    // State registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            flushp_q  <= 1'b0;
            asm_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            flushp_q  <= flushp_d;
            asm_q     <= asm_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a byte FIFO model with registered read feeds
// the DUT, directed sequences push expected words into a scoreboard and a
// monitor compares every accepted word plus reset, hold and pop behaviour.
module tb_fifo_word_packer;

    localparam int DW    = 8;
    localparam int BYTES = 4;
    localparam int CW    = 3;
    localparam int WW    = DW * BYTES;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] fifo_dout;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [WW-1:0] m_data;
    logic [CW-1:0] m_count;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [CW-1:0] count;
    } word_t;

    word_t         expq[$];
    logic [DW-1:0] fq[$];

    int checks       = 0;
    int failures     = 0;
    bit done         = 1'b0;
    bit timeout_seen = 1'b0;

    always #5 clk = ~clk;

    fifo_word_packer #(.DW(DW), .BYTES(BYTES), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .fifo_dout (fifo_dout),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_count   (m_count)
    );

    // One clock cycle starting at a falling edge: sample the pop request,
    // cross the rising edge, then model the FIFO's registered read port.
    task automatic tick();
        logic popped;
        #1;
        popped = fifo_pop;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (popped && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic expect_word(input logic [WW-1:0] d, input logic [CW-1:0] c);
        word_t w;
        w.data  = d;
        w.count = c;
        expq.push_back(w);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (expq.size() != 0) timeout_seen = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (m_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (m_valid !== 1'b1) timeout_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Stimulus
    initial begin : stim
        rstn       = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        #1 rstn = 1'b0;
        @(negedge clk);
        idle(2);
        rstn = 1'b1;
        idle(1);

        // Four bytes, ready downstream: one full word.
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_word(32'h44332211, 3'd4);
        wait_drain(30);
        idle(2);

        // Two words with a five-cycle stall on the first.
        m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push(8'h11); push(8'h22); push(8'h33); push(8'h44);
            expect_word(32'h44332211, 3'd4);
        end
        wait_valid(30);
        idle(5);
        m_ready = 1'b1;
        wait_drain(40);
        idle(2);

        // Partial word of two bytes released by flush.
        push(8'hAA); push(8'hBB);
        expect_word(32'h0000BBAA, 3'd2);
        idle(5);
        flush = 1'b1;
        tick();
        wait_drain(20);
        idle(3);

        // Flush raised in the same cycle as the third pop.
        push(8'hAA); push(8'hBB); push(8'hCC);
        expect_word(32'h00CCBBAA, 3'd3);
        tick();
        tick();
        flush = 1'b1;
        tick();
        wait_drain(20);
        idle(3);

        // Flush with nothing assembled, then normal packing resumes.
        flush = 1'b1;
        tick();
        idle(3);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        expect_word(32'h04030201, 3'd4);
        wait_drain(30);
        idle(2);

        // Flush on the cycle the word completes: only the full word appears.
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        expect_word(32'h88776655, 3'd4);
        idle(4);
        flush = 1'b1;
        tick();
        wait_drain(20);
        idle(4);
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        expect_word(32'hD4C3B2A1, 3'd4);
        wait_drain(30);
        idle(2);

        // Reset while a word is held; the held word is discarded.
        m_ready = 1'b0;
        push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
        wait_valid(30);
        idle(2);
        #1 rstn = 1'b0;
        tick();
        tick();
        rstn    = 1'b1;
        m_ready = 1'b1;
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        expect_word(32'h78563412, 3'd4);
        wait_drain(30);
        idle(3);

        done = 1'b1;
    end

    // Monitor and scoreboard, sampled late in the low phase of the clock.
    initial begin : monitor
        int            cyc        = 0;
        int            last_pop   = -100;
        bit            prev_stall = 1'b0;
        bit            prev_valid = 1'b0;
        logic [WW-1:0] prev_data  = '0;
        logic [CW-1:0] prev_count = '0;
        word_t         e;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (done || cyc > 4000) begin
                checks++;
                if (!done) begin
                    failures++;
                    $display("FAIL watchdog: stimulus done=0, required 1");
                end
                checks++;
                if (expq.size() != 0) begin
                    failures++;
                    $display("FAIL leftover_words: pending=%0d, required 0", expq.size());
                end
                checks++;
                if (timeout_seen) begin
                    failures++;
                    $display("FAIL wait_timeout: timeout_seen=1, required 0");
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (!rstn) begin
                checks++;
                if (m_valid !== 1'b0 || m_data !== '0 || m_count !== '0 || fifo_pop !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state: valid=%b data=%h count=%0d pop=%b, required all zero",
                             m_valid, m_data, m_count, fifo_pop);
                end
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== prev_data || m_count !== prev_count) begin
                        failures++;
                        $display("FAIL hold: valid=%b data=%h count=%0d, required 1 %h %0d",
                                 m_valid, m_data, m_count, prev_data, prev_count);
                    end
                end
                if (m_valid) begin
                    checks++;
                    if (fifo_pop !== 1'b0) begin
                        failures++;
                        $display("FAIL pop_during_valid: pop=%b, required 0", fifo_pop);
                    end
                end
                if (fifo_pop === 1'b1) begin
                    checks++;
                    if (fifo_empty) begin
                        failures++;
                        $display("FAIL pop_when_empty: pop=1 with empty=1, required pop=0");
                    end
                    last_pop = cyc;
                end
                if (m_valid && !prev_valid && m_count == CW'(BYTES)) begin
                    checks++;
                    if (cyc - last_pop != 2) begin
                        failures++;
                        $display("FAIL word_latency: %0d cycles after last pop, required 2", cyc - last_pop);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word: data=%h count=%0d, required no word", m_data, m_count);
                    end else begin
                        e = expq.pop_front();
                        if (m_data !== e.data || m_count !== e.count) begin
                            failures++;
                            $display("FAIL word: data=%h count=%0d, required data=%h count=%0d",
                                     m_data, m_count, e.data, e.count);
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_valid = m_valid;
                prev_data  = m_data;
                prev_count = m_count;
            end
        end
    end

endmodule
